// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter for the shared data-memory line port.
// Holds a grant until the memory acks; a watchdog aborts grants that never complete.
module mem_port_arbiter #(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_ack_o,

  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_ack_o,

  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,

  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  localparam int unsigned WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  // One-hot grant encoding so the state doubles as grant_o.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                timeout_q, timeout_d;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state: arbitration in IDLE, ack/watchdog exit from a grant
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (p0_enable_i && (!p1_enable_i || last_q)) begin
          state_d = ST_GNT0;
          last_d  = 1'b0;
          wdog_d  = '0;
        end else if (p1_enable_i) begin
          state_d = ST_GNT1;
          last_d  = 1'b1;
          wdog_d  = '0;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (mem_ack_i) begin
          state_d = ST_IDLE;
        end else if (wdog_q == WDOG_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: memory side steered from the granted port, ack passed straight through
  always_comb begin
    grant_o      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    p0_ack_o     = 1'b0;
    p1_ack_o     = 1'b0;
    unique case (state_q)
      ST_GNT0: begin
        mem_enable_o = 1'b1;
        mem_write_o  = p0_write_i;
        mem_addr_o   = p0_addr_i;
        mem_data_o   = p0_data_i;
        p0_ack_o     = mem_ack_i;
      end
      ST_GNT1: begin
        mem_enable_o = 1'b1;
        mem_write_o  = p1_write_i;
        mem_addr_o   = p1_addr_i;
        mem_data_o   = p1_data_i;
        p1_ack_o     = mem_ack_i;
      end
      default: ;
    endcase
  end

  assign p0_data_o = mem_data_i;
  assign p1_data_o = mem_data_i;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a default instance and a TIMEOUT=8 instance share
// stimulus and are checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned DW   = 256;
  localparam int unsigned AW   = 32;
  localparam int unsigned TO_A = 1023;
  localparam int unsigned TO_B = 8;

  logic clk = 1'b0;
  logic rst_i;
  logic p0_enable_i, p0_write_i, p1_enable_i, p1_write_i, mem_ack_i;
  logic [AW-1:0] p0_addr_i, p1_addr_i;
  logic [DW-1:0] p0_data_i, p1_data_i, mem_data_i;

  logic [DW-1:0] p0_data_a, p1_data_a, mem_data_a, p0_data_b, p1_data_b, mem_data_b;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic p0_ack_a, p1_ack_a, mem_enable_a, mem_write_a, timeout_a;
  logic p0_ack_b, p1_ack_b, mem_enable_b, mem_write_b, timeout_b;
  logic [1:0] grant_a, grant_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut_a (
    .clk_i(clk), .rst_i(rst_i),
    .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
    .p0_data_i(p0_data_i), .p0_data_o(p0_data_a), .p0_ack_o(p0_ack_a),
    .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_data_o(p1_data_a), .p1_ack_o(p1_ack_a),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .mem_data_o(mem_data_a),
    .mem_addr_o(mem_addr_a), .mem_enable_o(mem_enable_a), .mem_write_o(mem_write_a),
    .grant_o(grant_a), .timeout_o(timeout_a)
  );

  mem_port_arbiter #(.TIMEOUT(TO_B)) dut_b (
    .clk_i(clk), .rst_i(rst_i),
    .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
    .p0_data_i(p0_data_i), .p0_data_o(p0_data_b), .p0_ack_o(p0_ack_b),
    .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
    .p1_data_i(p1_data_i), .p1_data_o(p1_data_b), .p1_ack_o(p1_ack_b),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .mem_data_o(mem_data_b),
    .mem_addr_o(mem_addr_b), .mem_enable_o(mem_enable_b), .mem_write_o(mem_write_b),
    .grant_o(grant_b), .timeout_o(timeout_b)
  );

  // Reference model: which port owns the memory (-1 = nobody), who went last,
  // how many cycles the current owner has waited, and the sticky abort flag.
  int m_g    [2] = '{-1, -1};
  bit m_last [2];
  int m_age  [2];
  bit m_to   [2];

  function automatic int pick(bit r0, bit r1, bit last);
    if (r0 && r1) return last ? 0 : 1;
    return r0 ? 0 : 1;
  endfunction

  always @(posedge clk or negedge rst_i) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_i) begin
        m_g[k] <= -1; m_last[k] <= 1'b0; m_age[k] <= 0; m_to[k] <= 1'b0;
      end else if (m_g[k] < 0) begin
        if (p0_enable_i || p1_enable_i) begin
          m_g[k]    <= pick(p0_enable_i, p1_enable_i, m_last[k]);
          m_last[k] <= (pick(p0_enable_i, p1_enable_i, m_last[k]) == 1);
          m_age[k]  <= 0;
        end
      end else if (mem_ack_i) begin
        m_g[k] <= -1;
      end else if (m_age[k] + 1 >= ((k == 0) ? int'(TO_A) : int'(TO_B))) begin
        m_g[k] <= -1; m_to[k] <= 1'b1;
      end else begin
        m_age[k] <= m_age[k] + 1;
      end
    end
  end

  // Expected outputs: {grant[1], grant[0], enable, write, ack0, ack1, timeout}
  logic [6:0]    exp_ctl   [2];
  logic [AW-1:0] exp_addr  [2];
  logic [DW-1:0] exp_wdata [2];
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      exp_ctl[k]   = {(m_g[k] == 1), (m_g[k] == 0), (m_g[k] >= 0), 1'b0,
                      (m_g[k] == 0) && mem_ack_i, (m_g[k] == 1) && mem_ack_i, m_to[k]};
      exp_addr[k]  = '0;
      exp_wdata[k] = '0;
      if (m_g[k] == 0) begin
        exp_ctl[k][3] = p0_write_i; exp_addr[k] = p0_addr_i; exp_wdata[k] = p0_data_i;
      end else if (m_g[k] == 1) begin
        exp_ctl[k][3] = p1_write_i; exp_addr[k] = p1_addr_i; exp_wdata[k] = p1_data_i;
      end
    end
  end

  logic [6:0] obs_a, obs_b;
  assign obs_a = {grant_a, mem_enable_a, mem_write_a, p0_ack_a, p1_ack_a, timeout_a};
  assign obs_b = {grant_b, mem_enable_b, mem_write_b, p0_ack_b, p1_ack_b, timeout_b};

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < int'(DW / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    p0_enable_i = 1'b0; p0_write_i = 1'b0; p0_addr_i = '0; p0_data_i = '0;
    p1_enable_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
    mem_ack_i = 1'b0; mem_data_i = rand_line();
  endtask

  task automatic reset_pulse();
    @(negedge clk); rst_i = 1'b0; idle_inputs();
    @(negedge clk); rst_i = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_i = 1'b0; idle_inputs();
    #1;
    n_tests++;
    if ({obs_a, obs_b} !== 14'd0) begin
      n_fail++; $display("FAIL reset_ctl got a=%b b=%b need 0", obs_a, obs_b);
    end
    n_tests++;
    if ({mem_addr_a, mem_data_a, mem_addr_b, mem_data_b} !== '0) begin
      n_fail++; $display("FAIL reset_bus got addr %h/%h need 0", mem_addr_a, mem_addr_b);
    end
    @(negedge clk); rst_i = 1'b1;
  endtask

  task automatic test_p1_read();
    logic [DW-1:0] line;
    @(negedge clk);
    p1_enable_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h40; p1_data_i = rand_line();
    #1;
    n_tests++;
    if (grant_a !== 2'b00) begin n_fail++; $display("FAIL p1rd_lat got %b need 00", grant_a); end
    for (int s = 1; s <= 11; s++) begin
      @(negedge clk);
      line = rand_line(); mem_data_i = line; mem_ack_i = (s == 10);
      if (s == 11) p1_enable_i = 1'b0;
      #1;
      n_tests++;
      if ({obs_a, obs_b} !== {exp_ctl[0], exp_ctl[1]}) begin
        n_fail++; $display("FAIL p1rd_ctl s=%0d got %b/%b need %b/%b", s, obs_a, obs_b, exp_ctl[0], exp_ctl[1]);
      end
      n_tests++;
      if (grant_a !== ((s <= 10) ? 2'b10 : 2'b00) || p1_ack_a !== (s == 10) || p0_ack_a !== 1'b0) begin
        n_fail++; $display("FAIL p1rd_dir s=%0d got grant=%b ack1=%b ack0=%b", s, grant_a, p1_ack_a, p0_ack_a);
      end
      n_tests++;
      if (p1_data_a !== line || mem_addr_a !== ((s <= 10) ? 32'h40 : 32'h0)) begin
        n_fail++; $display("FAIL p1rd_bus s=%0d got data=%h addr=%h need data=%h", s, p1_data_a[63:0], mem_addr_a, line[63:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int phase;
    logic [1:0] want;
    reset_pulse();
    @(negedge clk);
    p0_enable_i = 1'b1; p0_addr_i = 32'h100; p0_write_i = 1'b0;
    p1_enable_i = 1'b1; p1_addr_i = 32'h200; p1_write_i = 1'b1; p1_data_i = rand_line();
    for (int s = 1; s <= 16; s++) begin
      @(negedge clk);
      phase = (s - 1) % 8;
      mem_ack_i = (phase == 2 || phase == 6);
      if (s == 16) begin p0_enable_i = 1'b0; p1_enable_i = 1'b0; end
      #1;
      want = (phase < 3) ? 2'b10 : (phase == 3) ? 2'b00 : (phase < 7) ? 2'b01 : 2'b00;
      n_tests++;
      if (grant_a !== want || grant_b !== want) begin
        n_fail++; $display("FAIL b2b_order s=%0d got %b/%b need %b", s, grant_a, grant_b, want);
      end
      n_tests++;
      if ({obs_a, obs_b} !== {exp_ctl[0], exp_ctl[1]}) begin
        n_fail++; $display("FAIL b2b_ctl s=%0d got %b/%b need %b/%b", s, obs_a, obs_b, exp_ctl[0], exp_ctl[1]);
      end
    end
  endtask

  task automatic test_write_mid();
    logic [DW-1:0] a5;
    logic [1:0] want;
    a5 = {32{8'hA5}};
    @(negedge clk);
    p0_enable_i = 1'b1; p0_write_i = 1'b1; p0_addr_i = 32'h80; p0_data_i = a5;
    for (int s = 1; s <= 9; s++) begin
      @(negedge clk);
      mem_data_i = rand_line(); mem_ack_i = (s == 5 || s == 8);
      if (s == 2) begin p1_enable_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'hC0; end
      if (s == 6) p0_enable_i = 1'b0;
      if (s == 9) p1_enable_i = 1'b0;
      #1;
      want = (s <= 5) ? 2'b01 : (s == 6) ? 2'b00 : (s <= 8) ? 2'b10 : 2'b00;
      n_tests++;
      if (grant_a !== want) begin n_fail++; $display("FAIL wr_grant s=%0d got %b need %b", s, grant_a, want); end
      if (s <= 5) begin
        n_tests++;
        if (mem_write_a !== 1'b1 || mem_addr_a !== 32'h80 || mem_data_a !== a5) begin
          n_fail++; $display("FAIL wr_bus s=%0d got wr=%b addr=%h data=%h", s, mem_write_a, mem_addr_a, mem_data_a[63:0]);
        end
      end
      n_tests++;
      if ({mem_addr_a, mem_data_a, mem_addr_b, mem_data_b} !== {exp_addr[0], exp_wdata[0], exp_addr[1], exp_wdata[1]}) begin
        n_fail++; $display("FAIL wr_model s=%0d got addr %h/%h need %h/%h", s, mem_addr_a, mem_addr_b, exp_addr[0], exp_addr[1]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [1:0] want;
    reset_pulse();
    @(negedge clk);
    p0_enable_i = 1'b1; p0_write_i = 1'b0; p0_addr_i = 32'h300;
    for (int s = 1; s <= 20; s++) begin
      @(negedge clk);
      mem_ack_i = (s == 8 || s == 19);
      if (s == 20) p0_enable_i = 1'b0;
      #1;
      want = (s == 9 || s == 18 || s == 20) ? 2'b00 : 2'b01;
      n_tests++;
      if (grant_b !== want || timeout_b !== (s >= 18) || p0_ack_b !== (s == 8 || s == 19)) begin
        n_fail++; $display("FAIL tmo_dir s=%0d got grant=%b tmo=%b ack=%b need grant=%b", s, grant_b, timeout_b, p0_ack_b, want);
      end
      n_tests++;
      if ({obs_a, obs_b} !== {exp_ctl[0], exp_ctl[1]}) begin
        n_fail++; $display("FAIL tmo_ctl s=%0d got %b/%b need %b/%b", s, obs_a, obs_b, exp_ctl[0], exp_ctl[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    p1_enable_i = 1'b1; p1_addr_i = 32'h440;
    @(negedge clk); #1;
    n_tests++;
    if (grant_a !== 2'b10 || mem_enable_a !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre got grant=%b en=%b need 10/1", grant_a, mem_enable_a);
    end
    @(posedge clk); #2;
    rst_i = 1'b0;
    #1;
    n_tests++;
    if ({mem_enable_a, grant_a, mem_enable_b, grant_b} !== 6'd0) begin
      n_fail++; $display("FAIL rstmid_async got en=%b grant=%b en_b=%b grant_b=%b need 0", mem_enable_a, grant_a, mem_enable_b, grant_b);
    end
    @(negedge clk);
    rst_i = 1'b1; p0_enable_i = 1'b1; p0_addr_i = 32'h500;
    @(negedge clk); #1;
    n_tests++;
    if (grant_a !== 2'b10 || grant_b !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_tie got %b/%b need 10", grant_a, grant_b);
    end
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      mem_ack_i = (s == 0 || s == 2);
      if (s == 1) p1_enable_i = 1'b0;
      if (s == 3) p0_enable_i = 1'b0;
      #1;
      n_tests++;
      if ({obs_a, obs_b} !== {exp_ctl[0], exp_ctl[1]}) begin
        n_fail++; $display("FAIL rstmid_ctl s=%0d got %b/%b need %b/%b", s, obs_a, obs_b, exp_ctl[0], exp_ctl[1]);
      end
    end
  endtask

  task automatic test_spurious_ack();
    @(negedge clk); idle_inputs();
    @(negedge clk);
    mem_ack_i = 1'b1;
    #1;
    n_tests++;
    if ({p0_ack_a, p1_ack_a, p0_ack_b, p1_ack_b, grant_a, grant_b} !== 8'd0) begin
      n_fail++; $display("FAIL spur_ack got acks=%b%b%b%b grants=%b/%b need 0", p0_ack_a, p1_ack_a, p0_ack_b, p1_ack_b, grant_a, grant_b);
    end
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    n_tests++;
    if ({obs_a, obs_b} !== {exp_ctl[0], exp_ctl[1]} || grant_a !== 2'b00) begin
      n_fail++; $display("FAIL spur_state got %b/%b need %b/%b", obs_a, obs_b, exp_ctl[0], exp_ctl[1]);
    end
  endtask

  task automatic test_random();
    bit clr0 = 1'b0;
    bit clr1 = 1'b0;
    reset_pulse();
    for (int s = 0; s < 400; s++) begin
      @(negedge clk);
      if (clr0) p0_enable_i = 1'b0;
      else if (!p0_enable_i && $urandom_range(2) == 0) begin
        p0_enable_i = 1'b1; p0_write_i = 1'($urandom_range(1)); p0_addr_i = $urandom; p0_data_i = rand_line();
      end
      if (clr1) p1_enable_i = 1'b0;
      else if (!p1_enable_i && $urandom_range(2) == 0) begin
        p1_enable_i = 1'b1; p1_write_i = 1'($urandom_range(1)); p1_addr_i = $urandom; p1_data_i = rand_line();
      end
      mem_data_i = rand_line();
      mem_ack_i  = ($urandom_range(4) == 0);
      #1;
      n_tests++;
      if ({obs_a, obs_b} !== {exp_ctl[0], exp_ctl[1]}) begin
        n_fail++; $display("FAIL rand_ctl s=%0d got %b/%b need %b/%b", s, obs_a, obs_b, exp_ctl[0], exp_ctl[1]);
      end
      n_tests++;
      if ({mem_addr_a, mem_data_a, mem_addr_b, mem_data_b} !== {exp_addr[0], exp_wdata[0], exp_addr[1], exp_wdata[1]} ||
          {p0_data_a, p1_data_a, p0_data_b, p1_data_b} !== {4{mem_data_i}}) begin
        n_fail++; $display("FAIL rand_bus s=%0d got addr %h/%h need %h/%h wdata %h need %h", s, mem_addr_a, mem_addr_b,
                           exp_addr[0], exp_addr[1], mem_data_a[63:0], exp_wdata[0][63:0]);
      end
      clr0 = exp_ctl[0][2];
      clr1 = exp_ctl[0][1];
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    #1 rst_i = 1'b0;
    test_reset();
    test_p1_read();
    test_back_to_back();
    test_write_mid();
    test_timeout();
    test_reset_mid();
    test_spurious_ack();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single 256-bit data-memory port between the instruction-side refill path (port 0) and the data cache (`dcache_top`, port 1). It sits between the CPU's cache controllers and the off-chip `Data_Memory` model and uses the existing enable/write/ack memory handshake on both sides. It grants one transaction at a time, using round-robin on ties, and holds the grant until the memory acks. A watchdog aborts a transaction if the ack never arrives.

## Interface
Parameters:
- `DATA_W`, 256, memory line width in bits.
- `ADDR_W`, 32, byte address width.
- `TIMEOUT`, 1023, maximum cycles in a granted state without an ack before abort; legal range 2..65535.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `p0_enable_i`  in  1  port 0 request; held high until `p0_ack_o`.
- `p0_write_i`  in  1  port 0: 1 = write, 0 = read.
- `p0_addr_i`  in  ADDR_W  port 0 line address.
- `p0_data_i`  in  DATA_W  port 0 write data.
- `p0_data_o`  out  DATA_W  port 0 read data; mirrors `mem_data_i`.
- `p0_ack_o`  out  1  port 0 completion pulse.
- `p1_enable_i`, `p1_write_i`, `p1_addr_i`, `p1_data_i`, `p1_data_o`, `p1_ack_o`: same as port 0, for the data cache.
- `mem_data_i`  in  DATA_W  memory read data; valid when `mem_ack_i` is high.
- `mem_ack_i`  in  1  memory completion pulse.
- `mem_data_o`  out  DATA_W  write data to memory.
- `mem_addr_o`  out  ADDR_W  address to memory.
- `mem_enable_o`  out  1  memory request.
- `mem_write_o`  out  1  memory write strobe.
- `grant_o`  out  2  one-hot current grant; `[0]` = port 0, `[1]` = port 1, `00` = idle.
- `timeout_o`  out  1  sticky watchdog flag.

## Operation
- FSM states: IDLE, GNT0, GNT1. Two further registers: `last` (1 bit, port of the most recent grant) and `wdog` (cycle counter).
- IDLE transitions:
  - only `p0_enable_i` high: go to GNT0.
  - only `p1_enable_i` high: go to GNT1.
  - both high: grant the port that is not `last`.
  - neither high: stay in IDLE.
  - On entering GNTx: `last <= x`, `wdog <= 0`.
- GNTx behaviour:
  - Memory outputs (`mem_enable_o`, `mem_write_o`, `mem_addr_o`, `mem_data_o`) are driven from port x's inputs. `mem_enable_o` = 1 for the whole state, even if port x drops its enable early.
  - `px_ack_o` = `mem_ack_i`, combinational, in the same cycle.
  - The other port's ack = 0.
- GNTx exit:
  - `mem_ack_i` = 1: go to IDLE.
  - Otherwise, if `wdog` = TIMEOUT-1: go to IDLE, set `timeout_o`, and issue no ack. The requester keeps its enable high and is retried.
  - Otherwise: `wdog` increments.
- If ack and the watchdog terminal count occur in the same cycle, the ack wins: normal completion, `timeout_o` unchanged.
- `mem_ack_i` while in IDLE is ignored; no port ack is generated.
- IDLE outputs: `mem_enable_o` = 0, `mem_write_o` = 0, `mem_addr_o` = 0, `mem_data_o` = 0.
- `p0_data_o` and `p1_data_o` always equal `mem_data_i`. Only the port's ack qualifies the data.
- `timeout_o` clears only on reset.
- Width rule: `wdog` is clog2(TIMEOUT) bits and never wraps, because it is cleared on every grant.

## Timing
- Reset values: state IDLE, `last` = 0 (so port 1 wins the first tie), `wdog` = 0, `timeout_o` = 0, `grant_o` = 00, both acks 0, all `mem_*` outputs 0.
- Reset asserted mid-transaction: return to IDLE immediately and drop `mem_enable_o` asynchronously.
- Arbitration latency is one cycle. A request first high in cycle t is sampled at the end of t, and `mem_enable_o` goes high in t+1.
- Completion: ack in cycle k, IDLE in k+1. A request still held in k+1 is granted in k+2.
- Minimum spacing between two transactions is therefore one IDLE cycle.
- Back-to-back requests from both ports alternate strictly.

## Test plan
- Reset, then port 1 read at addr 0x40 with memory ack after 10 cycles:
  - `grant_o` = 10 from the cycle after the request.
  - `p1_ack_o` pulses in the same cycle as `mem_ack_i`, and `p1_data_o` equals the memory line.
  - `p0_ack_o` stays 0.
- Both ports request in the same cycle after reset, held continuously, memory acks each after 3 cycles:
  - grant order is 1, 0, 1, 0.
  - each grant is separated by exactly one IDLE cycle.
- Port 0 write of 0xA5…A5 to 0x80 while port 1 raises a request mid-transaction:
  - `mem_write_o` = 1 and `mem_addr_o` = 0x80 until the ack.
  - port 1 is granted two cycles after the ack.
- TIMEOUT = 8, no memory ack:
  - after 8 granted cycles, state returns to IDLE and `timeout_o` = 1 (sticky).
  - the held request is re-granted in the next cycle.
  - `mem_ack_i` arriving in the 8th granted cycle instead completes normally with `timeout_o` = 0.
- `rst_i` pulled low during GNT1:
  - `mem_enable_o` and `grant_o` clear without waiting for a clock edge.
  - after release, the first tie goes to port 1.
- Spurious `mem_ack_i` while in IDLE: no port ack and no state change.
